dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DATA_W, 16, data word width in bits.
REQ-002 Parameter ADDR_W, 16, request address width in bits.
REQ-003 Parameter DEPTH, 256, number of implemented memory words (DEPTH <= 2^ADDR_W).
REQ-004 Parameter WAIT_CYC, 2, wait states inserted between acceptance and response (0..15).
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_f  input  1  reset, asynchronous, active-low.
REQ-007 Port req  input  1  memory request from the control FSM, level-held until ack.
REQ-008 Port we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 Port addr  input  ADDR_W  word address; sampled with req.
REQ-010 Port wdata  input  DATA_W  write data; sampled with req.
REQ-011 Port ack  output  1  one-cycle completion pulse.
REQ-012 Port rdata  output  DATA_W  read data; valid while ack=1.
REQ-013 Port busy  output  1  1 while a request is in flight (states WAIT and RESP).
REQ-014 Port err  output  1  out-of-range flag; valid while ack=1.

Function
REQ-015 The block SHALL implement a registered FSM with states IDLE, WAIT, RESP.
REQ-016 In IDLE with req=1 at a rising edge (acceptance edge A), the block SHALL latch we, addr and wdata and enter WAIT, or enter RESP directly when WAIT_CYC=0.
REQ-017 In IDLE with req=0, the block SHALL remain in IDLE with ack=0, busy=0.
REQ-018 A 4-bit wait counter SHALL load WAIT_CYC-1 on entry to WAIT, decrement each cycle, and transition WAIT->RESP at the edge where it is 0; WAIT therefore lasts exactly WAIT_CYC cycles.
REQ-019 ack SHALL be 1 exactly while in state RESP, i.e. for the single cycle following edge A+WAIT_CYC; RESP SHALL always transition to IDLE on the next edge.
REQ-020 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-021 An address is in range when latched addr < DEPTH; address arithmetic SHALL be unsigned and SHALL NOT wrap modulo DEPTH.
REQ-022 An in-range write SHALL update memory at the edge that enters RESP; err SHALL be 0; rdata SHALL be 0.
REQ-023 An in-range read SHALL present mem[addr] on rdata during RESP, reflecting all writes completed before the edge that enters RESP.
REQ-024 An out-of-range request SHALL NOT modify memory; err SHALL be 1 and rdata SHALL be 0 during RESP.
REQ-025 rdata and err SHALL be 0 whenever ack=0.
REQ-026 Changes on req, we, addr and wdata after acceptance SHALL be ignored until the block returns to IDLE.
REQ-027 If req is still 1 in the RESP cycle, it SHALL NOT be accepted there; the earliest next acceptance is the first edge in IDLE, giving a minimum request spacing of WAIT_CYC+2 cycles.
REQ-028 A write followed by a read of the same address SHALL return the newly written data.
REQ-029 The block SHALL contain no combinational path from any input to ack, busy, rdata or err.

Reset
REQ-030 When rst_f=0, the block SHALL asynchronously force state IDLE, wait counter 0, ack=0, busy=0, err=0 and rdata=0, regardless of clk.
REQ-031 Reset asserted during WAIT SHALL discard the pending request; a pending write SHALL NOT be committed.
REQ-032 Memory contents SHALL NOT be cleared by reset; their initial contents are undefined.
REQ-033 After rst_f deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_f=1 and req=1.

Verification
REQ-034 With WAIT_CYC=2: write addr=0x0010, wdata=0xBEEF, accepted at edge A -> busy=1 from A; ack=1, err=0 for exactly the cycle after A+2; busy=0 after A+3.
REQ-035 Read addr=0x0010 immediately after REQ-034 -> ack in the cycle after A'+2 with rdata=0xBEEF, err=0; acceptance-to-acceptance spacing of exactly 4 cycles with req held high.
REQ-036 Write addr=0x0100 (=DEPTH), wdata=0x1234, then read 0x0000 -> write ack with err=1, rdata=0; read returns the prior mem[0] value unchanged.
REQ-037 Start a write to 0x0020 with 0xAAAA; drop rst_f mid-WAIT for 1 ns between edges -> ack, busy and rdata=0 immediately; a later read of 0x0020 returns its pre-write value.
REQ-038 Build with WAIT_CYC=0: read accepted at A -> ack in the cycle after A; toggling addr and we during RESP does not alter rdata.

Source files
------------

// File: rtl/dmem_resp.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : dmem_resp
// Purpose  : Single-port data memory with a fixed number of wait states.
//            A level-held request is accepted in IDLE and waits WAIT_CYC
//            cycles. The block then answers with a one-cycle ack. During
//            that cycle it presents the read data or an out-of-range flag.
// Ports    : clk    - clock, rising edge
//            rst_f  - asynchronous active-low reset
//            req    - request, held until ack
//            we     - 1 = write, 0 = read (sampled with req)
//            addr   - word address (sampled with req)
//            wdata  - write data (sampled with req)
//            ack    - one-cycle completion pulse
//            rdata  - read data, valid while ack=1, otherwise 0
//            busy   - request in flight (WAIT or RESP)
//            err    - address out of range, valid while ack=1, otherwise 0
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      c_WAIT_LOAD = 4'(WAIT_CYC - 1);
    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [3:0]          r_cnt_q;
    logic [3:0]          w_cnt_d;
    logic                r_we_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_wdata_q;
    logic [DATA_W-1:0]   r_rdata_q;
    logic [DATA_W-1:0]   w_rdata_d;
    logic                r_err_q;
    logic                w_err_d;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_take;
    logic                w_enter_resp;
    logic                w_cur_we;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]   w_cur_wdata;
    logic                w_in_range;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_commit;

    // Next-state logic and wait counter.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYC == 0) begin
                        w_state_d = S_RESP;
                    end else begin
                        w_state_d = S_WAIT;
                        w_cnt_d   = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            S_RESP:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    assign w_take       = (r_state_q == S_IDLE) && req;
    assign w_enter_resp = (w_state_d == S_RESP) && (r_state_q != S_RESP);

    // With zero wait states, the response is formed at the acceptance edge
    // itself. In that case the live inputs stand in for the latched request.
    assign w_cur_we    = (r_state_q == S_IDLE) ? we    : r_we_q;
    assign w_cur_addr  = (r_state_q == S_IDLE) ? addr  : r_addr_q;
    assign w_cur_wdata = (r_state_q == S_IDLE) ? wdata : r_wdata_q;

    // Compare one bit wider so that DEPTH == 2**ADDR_W stays representable.
    assign w_in_range = ({1'b0, w_cur_addr} < c_DEPTH_EXT);
    assign w_idx      = w_cur_addr[c_IDX_W-1:0];

    // The memory write must not fire on an edge taken while reset is held.
    assign w_commit = w_enter_resp && w_in_range && w_cur_we && rst_f;

    assign w_rdata_d = (w_enter_resp && w_in_range && !w_cur_we) ? r_mem[w_idx] : '0;
    assign w_err_d   = w_enter_resp && !w_in_range;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 4'd0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            if (w_take) begin
                r_we_q    <= we;
                r_addr_q  <= addr;
                r_wdata_q <= wdata;
            end
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
        end
    end

    // Storage is deliberately not reset; its contents survive rst_f.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

    assign ack   = (r_state_q == S_RESP);
    assign busy  = (r_state_q != S_IDLE);
    assign rdata = r_rdata_q;
    assign err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_dmem_resp
// Purpose  : Randomized scoreboard bench for dmem_resp. The main instance
//            uses two wait states. A second instance uses zero wait states
//            and is exercised with a short directed sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    localparam int DEPTH = 256;
    localparam int WC    = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_f;
    logic        req, we, ack, busy, err;
    logic [15:0] addr, wdata, rdata;
    logic        req0, we0, ack0, busy0, err0;
    logic [15:0] addr0, wdata0, rdata0;

    dmem_resp #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(WC)) u_dut (
        .clk(clk), .rst_f(rst_f), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .err(err)
    );

    dmem_resp #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_f(rst_f), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int earliest = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected response. acc is the accepting edge and ackc the edge that
    // raises ack; cycle numbers are the value of cyc after that edge.
    typedef struct {
        int          acc;
        int          ackc;
        logic [15:0] rd;
        logic        er;
        bit          aborted;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Issue one request and return at the negedge of its ack cycle.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input bit garble);
        exp_t e;
        int   acc;
        acc = (cyc + 1 > earliest) ? cyc + 1 : earliest;
        e.acc     = acc;
        e.ackc    = acc + WC;
        e.aborted = 1'b0;
        if (a < DEPTH) begin
            e.er = 1'b0;
            if (w) begin
                e.rd = 16'h0000;
                model_mem[a[7:0]] = d;
            end else begin
                e.rd = model_mem[a[7:0]];
            end
        end else begin
            e.er = 1'b1;
            e.rd = 16'h0000;
        end
        sbq.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
        while (cyc < acc) @(negedge clk);
        while (cyc < e.ackc) begin
            if (garble) begin
                req   = 1'($urandom_range(0, 1));
                we    = 1'($urandom_range(0, 1));
                addr  = 16'($urandom);
                wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        req      = 1'b0;
        earliest = e.ackc + 2;
    endtask

    // Start a write to 0x0020 and pulse reset while it sits in WAIT.
    task automatic reset_mid_wait();
        exp_t e;
        int   acc;
        acc = (cyc + 1 > earliest) ? cyc + 1 : earliest;
        e.acc = acc; e.ackc = acc; e.rd = 16'h0000; e.er = 1'b0; e.aborted = 1'b1;
        sbq.push_back(e);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
        while (cyc < acc) @(negedge clk);
        req = 1'b0;
        #2;
        rst_f = 1'b0;
        #0.5;
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_err", err, 1'b0);
        #0.5;
        rst_f    = 1'b1;
        earliest = acc + 1;
    endtask

    task automatic monitor_step();
        logic exp_busy;
        exp_busy = 1'b0;
        foreach (sbq[i]) begin
            if (cyc >= sbq[i].acc && cyc <= sbq[i].ackc) exp_busy = 1'b1;
        end
        check("busy", busy, exp_busy);
        while (sbq.size() > 0 && sbq[0].ackc < cyc) begin
            if (!sbq[0].aborted) begin
                checks++;
                failures++;
                $display("FAIL ack_missing: got ack=0 expected ack=1 at cycle %0d", sbq[0].ackc);
            end
            void'(sbq.pop_front());
        end
        if (ack) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].aborted || sbq[0].ackc != cyc) begin
                failures++;
                $display("FAIL ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
            end else begin
                check("rdata", rdata, sbq[0].rd);
                check("err", err, sbq[0].er);
                void'(sbq.pop_front());
            end
        end else begin
            check("idle_rdata", rdata, 16'h0000);
            check("idle_err", err, 1'b0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rst_f) monitor_step();
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] v;
        rst_f = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) @(negedge clk);
        check("reset_ack", ack, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_err", err, 1'b0);
        check("reset_ack0", ack0, 1'b0);
        check("reset_busy0", busy0, 1'b0);
        rst_f  = 1'b1;
        mon_en = 1'b1;

        // Fill every word so that the model knows all contents.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 16'(i), 16'($urandom), 1'b0);

        // Write then read back-to-back with req held high.
        issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        // Out-of-range write at DEPTH must not alias onto word 0.
        issue(1'b1, 16'h0100, 16'h1234, 1'b0);
        issue(1'b0, 16'h0000, 16'h0000, 1'b0);
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        issue(1'b0, 16'h00FF, 16'h0000, 1'b0);
        // Write aborted by reset; the old contents must remain.
        reset_mid_wait();
        issue(1'b0, 16'h0020, 16'h0000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) a = 16'($urandom_range(0, DEPTH - 1));
            else if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(DEPTH - 2, DEPTH + 1));
            else a = 16'($urandom);
            issue(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("sb_drain", sbq.size(), 0);

        // Zero-wait-state instance: ack in the cycle right after acceptance.
        v = 16'($urandom);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = v;
        @(negedge clk); #1;
        check("z_wr_ack", ack0, 1'b1);
        check("z_wr_busy", busy0, 1'b1);
        check("z_wr_err", err0, 1'b0);
        check("z_wr_rdata", rdata0, 16'h0000);
        we0 = 1'b0;                       // req still high through RESP
        @(negedge clk); #1;
        check("z_resp_noaccept_ack", ack0, 1'b0);
        check("z_resp_noaccept_busy", busy0, 1'b0);
        @(negedge clk); #1;
        check("z_rd_ack", ack0, 1'b1);
        check("z_rd_rdata", rdata0, v);
        addr0 = 16'h0006; we0 = 1'b1; wdata0 = ~v;
        #1;
        check("z_rd_rdata_stable", rdata0, v);
        check("z_rd_err", err0, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
        @(negedge clk); #1;
        check("z_oor_ack", ack0, 1'b1);
        check("z_oor_err", err0, 1'b1);
        check("z_oor_rdata", rdata0, 16'h0000);
        req0 = 1'b0;
        @(negedge clk); #1;
        check("z_idle_ack", ack0, 1'b0);
        check("z_idle_err", err0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
